// File: rtl/instruction_sequencer.sv
// Multi-cycle control FSM for a Y86-style core: walks each instruction through
// fetch/decode/execute/memory/writeback/pc-update and drives the datapath strobes.
module instruction_sequencer #(
  parameter int unsigned CNT_W     = 16,
  parameter logic [3:0]  ICODE_MAX = 4'hB
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             fetch_valid,
  input  logic [3:0]       icode_input,
  input  logic             cond_true,
  input  logic             mem_ready,
  output logic             fetch_req,
  output logic             ir_load,
  output logic             alu_en,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             writeEnable0,
  output logic             writeEnable1,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic [3:0]       ins_len,
  output logic [2:0]       state,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PC_UPDATE = 3'd6,
    S_STOP      = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_icode;
  logic             r_halted;
  logic             r_error;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_set_halted;
  logic             w_set_error;

  function automatic logic is_mem_read(input logic [3:0] ic);
    return (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
  endfunction

  // State register, icode latch, sticky status and retired-instruction count
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_icode       <= 4'h0;
      r_halted      <= 1'b0;
      r_error       <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (ir_load) r_icode <= icode_input;
      if (w_set_halted) r_halted <= 1'b1;
      if (w_set_error) r_error <= 1'b1;
      if (r_state == S_PC_UPDATE) r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  // Next-state decode and per-state strobes; ir_load is the only Mealy output
  always_comb begin
    w_next_state = r_state;
    fetch_req    = 1'b0;
    ir_load      = 1'b0;
    alu_en       = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    writeEnable0 = 1'b0;
    writeEnable1 = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 2'd0;
    w_set_halted = 1'b0;
    w_set_error  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_FETCH;
        else       w_next_state = S_IDLE;
      end
      S_FETCH: begin
        fetch_req = 1'b1;
        ir_load   = fetch_valid;
        if (fetch_valid) begin
          if (icode_input > ICODE_MAX) begin
            w_next_state = S_STOP;
            w_set_error  = 1'b1;
          end else begin
            w_next_state = S_DECODE;
          end
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        case (r_icode)
          4'h0: begin
            w_next_state = S_STOP;
            w_set_halted = 1'b1;
          end
          4'h1:    w_next_state = S_PC_UPDATE;
          default: w_next_state = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        alu_en = 1'b1;
        if (is_mem_read(r_icode) || is_mem_write(r_icode)) w_next_state = S_MEMORY;
        else                                               w_next_state = S_WRITEBACK;
      end
      S_MEMORY: begin
        // read and write icode sets are disjoint, so the strobes never overlap
        mem_rd = is_mem_read(r_icode);
        mem_wr = is_mem_write(r_icode);
        if (mem_ready) w_next_state = S_WRITEBACK;
        else           w_next_state = S_MEMORY;
      end
      S_WRITEBACK: begin
        case (r_icode)
          4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: writeEnable0 = 1'b1;
          4'h2:    writeEnable0 = cond_true;
          default: writeEnable0 = 1'b0;
        endcase
        writeEnable1 = (r_icode == 4'h5) || (r_icode == 4'hB);
        w_next_state = S_PC_UPDATE;
      end
      S_PC_UPDATE: begin
        pc_write = 1'b1;
        case (r_icode)
          4'h8:    pc_sel = 2'd1;
          4'h7:    pc_sel = cond_true ? 2'd1 : 2'd0;
          4'h9:    pc_sel = 2'd2;
          default: pc_sel = 2'd0;
        endcase
        w_next_state = S_FETCH;
      end
      S_STOP:  w_next_state = S_STOP;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Instruction byte length; nothing is latched yet while idle
  always_comb begin
    if (r_state == S_IDLE) begin
      ins_len = 4'd0;
    end else begin
      case (r_icode)
        4'h0, 4'h1, 4'h9:       ins_len = 4'd1;
        4'h2, 4'h6, 4'hA, 4'hB: ins_len = 4'd2;
        4'h7, 4'h8:             ins_len = 4'd9;
        4'h3, 4'h4, 4'h5:       ins_len = 4'd10;
        default:                ins_len = 4'd0;
      endcase
    end
  end

  assign state       = r_state;
  assign halted      = r_halted;
  assign error       = r_error;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench: a driver issues random instructions and queues per-instruction
// expectations; a monitor reassembles each instruction's strobe trace and compares.
module tb_instruction_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [3:0]  icode_input = 4'h0;
  logic        cond_true = 1'b0;
  logic        mem_ready = 1'b0;
  logic        fetch_req, ir_load, alu_en, mem_rd, mem_wr;
  logic        writeEnable0, writeEnable1, pc_write, halted, error;
  logic [1:0]  pc_sel;
  logic [3:0]  ins_len;
  logic [2:0]  state;
  logic [15:0] instr_count;

  instruction_sequencer #(.CNT_W(16), .ICODE_MAX(4'hB)) dut (
    .clock(clock), .reset(reset), .start(start), .fetch_valid(fetch_valid),
    .icode_input(icode_input), .cond_true(cond_true), .mem_ready(mem_ready),
    .fetch_req(fetch_req), .ir_load(ir_load), .alu_en(alu_en), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .writeEnable0(writeEnable0), .writeEnable1(writeEnable1),
    .pc_write(pc_write), .pc_sel(pc_sel), .ins_len(ins_len), .state(state),
    .halted(halted), .error(error), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  icode;
    int          lat;
    int          alu_n, rd_n, wr_n, we0_n, we1_n, pcw_n;
    logic [1:0]  pc_sel;
    logic [3:0]  len;
    bit          halt, err;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: what one instruction should look like, from the icode rules alone
  function automatic exp_t model(input logic [3:0] ic, input bit cnd, input int w);
    exp_t e;
    bit rd, wr;
    rd = ic inside {4'h5, 4'h9, 4'hB};
    wr = ic inside {4'h4, 4'h8, 4'hA};
    e.icode = ic;
    e.halt  = (ic == 4'h0);
    e.err   = (ic > 4'hB);
    if (ic inside {4'h0, 4'h1, 4'h9})             e.len = 4'd1;
    else if (ic inside {4'h2, 4'h6, 4'hA, 4'hB})  e.len = 4'd2;
    else if (ic inside {4'h7, 4'h8})              e.len = 4'd9;
    else if (ic inside {4'h3, 4'h4, 4'h5})        e.len = 4'd10;
    else                                          e.len = 4'd0;
    e.alu_n = 0; e.rd_n = 0; e.wr_n = 0; e.we0_n = 0; e.we1_n = 0; e.pcw_n = 0;
    e.pc_sel = 2'd0;
    e.cnt = 16'd0;
    if (e.err) e.lat = 1;
    else if (e.halt) e.lat = 2;
    else if (ic == 4'h1) begin
      e.lat = 3; e.pcw_n = 1;
    end else begin
      e.lat   = (rd || wr) ? 6 + w : 5;
      e.alu_n = 1;
      e.rd_n  = rd ? w + 1 : 0;
      e.wr_n  = wr ? w + 1 : 0;
      e.we0_n = ((ic inside {4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) || (ic == 4'h2 && cnd)) ? 1 : 0;
      e.we1_n = (ic inside {4'h5, 4'hB}) ? 1 : 0;
      e.pcw_n = 1;
      if (ic == 4'h8 || (ic == 4'h7 && cnd)) e.pc_sel = 2'd1;
      else if (ic == 4'h9)                   e.pc_sel = 2'd2;
      else                                   e.pc_sel = 2'd0;
    end
    return e;
  endfunction

  // Monitor state
  bit         open = 1'b0;
  exp_t       cur;
  int         cyc, n_alu, n_rd, n_wr, n_we0, n_we1, n_pcw;
  logic [1:0] cap_sel;
  logic [3:0] cap_len;

  // Monitor: sample mid-cycle, rebuild each instruction's trace and score it
  always @(negedge clock) begin
    if (reset) begin
      open = 1'b0;
      sb.delete();
    end else begin
      chk("moore_strobes",
          ((fetch_req == (state == 3'd1)) && (alu_en == (state == 3'd3)) &&
           (pc_write == (state == 3'd6)) && (!(mem_rd || mem_wr) || state == 3'd4) &&
           (!(writeEnable0 || writeEnable1) || state == 3'd5) &&
           (!ir_load || (state == 3'd1 && fetch_valid)) && !(mem_rd && mem_wr)) ? 1 : 0, 1);
      if (open) begin
        cyc++;
        if (state == 3'd1 || state == 3'd7 || cyc > 40) begin
          if (cur.err) cap_len = ins_len;
          chk("latency", cyc, cur.lat);
          chk("end_state", state, (cur.halt || cur.err) ? 7 : 1);
          chk("alu_en_cycles", n_alu, cur.alu_n);
          chk("mem_rd_cycles", n_rd, cur.rd_n);
          chk("mem_wr_cycles", n_wr, cur.wr_n);
          chk("we0_cycles", n_we0, cur.we0_n);
          chk("we1_cycles", n_we1, cur.we1_n);
          chk("pc_write_cycles", n_pcw, cur.pcw_n);
          if (cur.pcw_n > 0) chk("pc_sel", cap_sel, cur.pc_sel);
          chk("ins_len", cap_len, cur.len);
          chk("halted", halted, cur.halt);
          chk("error", error, cur.err);
          chk("instr_count", instr_count, cur.cnt);
          open = 1'b0;
        end else begin
          n_alu += alu_en;  n_rd += mem_rd;  n_wr += mem_wr;
          n_we0 += writeEnable0;  n_we1 += writeEnable1;  n_pcw += pc_write;
          if (pc_write) cap_sel = pc_sel;
          if (state == 3'd2) cap_len = ins_len;
        end
      end
      if (ir_load) begin
        if (sb.size() == 0) begin
          chk("unexpected_accept", 1, 0);
        end else begin
          cur = sb.pop_front();
          open = 1'b1;
          cyc = 0; n_alu = 0; n_rd = 0; n_wr = 0; n_we0 = 0; n_we1 = 0; n_pcw = 0;
          cap_sel = 2'd3; cap_len = 4'hF;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; fetch_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_cnt = 16'd0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("start_to_fetch", state, 1);
  endtask

  // Driver: present one instruction and then walk the cycles it should occupy
  task automatic issue(input logic [3:0] ic, input bit cnd, input int w, input int gap);
    exp_t e;
    bit   memop;
    int   span;
    e = model(ic, cnd, w);
    if (e.pcw_n > 0) exp_cnt = exp_cnt + 16'd1;
    e.cnt = exp_cnt;
    sb.push_back(e);
    memop = (e.rd_n + e.wr_n) > 0;
    cond_true = cnd;
    repeat (gap) begin
      fetch_valid = 1'b0; icode_input = 4'($urandom); mem_ready = 1'($urandom);
      @(posedge clock); #1;
    end
    fetch_valid = 1'b1; icode_input = ic; mem_ready = memop ? 1'b0 : 1'($urandom);
    @(posedge clock); #1;
    span = (e.halt || e.err) ? e.lat + 3 : e.lat;
    for (int k = 1; k < span; k++) begin
      fetch_valid = 1'($urandom); icode_input = 4'($urandom); start = 1'($urandom);
      mem_ready = memop ? (k >= 3 + w) : 1'($urandom);
      @(posedge clock); #1;
    end
    fetch_valid = 1'b0; start = 1'b0;
    if (e.halt || e.err) begin
      chk("stop_hold_state", state, 7);
      chk("stop_hold_halted", halted, e.halt);
      chk("stop_hold_error", error, e.err);
      chk("stop_hold_count", instr_count, exp_cnt);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", state, 0);
    chk("reset_strobes", {fetch_req, ir_load, alu_en, mem_rd, mem_wr, writeEnable0,
                          writeEnable1, pc_write, pc_sel, ins_len, halted, error}, 0);
    chk("reset_count", instr_count, 0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("idle_without_start", state, 0);

    // Directed walk through the instruction classes
    do_start();
    issue(4'h1, 1'b0, 0, 0);
    issue(4'h3, 1'b0, 0, 1);
    issue(4'h5, 1'b0, 3, 0);
    issue(4'h7, 1'b1, 0, 0);
    issue(4'h7, 1'b0, 0, 2);
    issue(4'h2, 1'b0, 0, 0);
    issue(4'h2, 1'b1, 0, 0);
    issue(4'h0, 1'b0, 0, 0);

    do_reset();
    do_start();
    issue(4'hD, 1'b0, 0, 0);

    // Reset while a write is stalled in MEMORY
    do_reset();
    do_start();
    issue(4'h1, 1'b0, 0, 0);
    e = model(4'h4, 1'b0, 5);
    sb.push_back(e);
    cond_true = 1'b0; fetch_valid = 1'b1; icode_input = 4'h4; mem_ready = 1'b0;
    @(posedge clock); #1;
    fetch_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("pre_reset_state", state, 4);
    chk("pre_reset_mem_wr", mem_wr, 1);
    chk("pre_reset_count", instr_count, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_state", state, 0);
    chk("abort_mem_wr", mem_wr, 0);
    chk("abort_count", instr_count, 0);
    reset = 1'b0;
    exp_cnt = 16'd0;
    do_start();
    issue(4'hA, 1'b1, 1, 0);
    issue(4'h0, 1'b0, 0, 1);

    // Random programs, each ending in halt or an illegal icode
    for (int r = 0; r < 6; r++) begin
      do_reset();
      do_start();
      for (int i = 0; i < int'($urandom_range(8, 16)); i++)
        issue(4'($urandom_range(1, 11)), 1'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)));
      issue((r % 2 == 0) ? 4'h0 : 4'($urandom_range(12, 15)), 1'b0, 0, 0);
    end

    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    chk("no_open_instruction", open, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Multi-cycle control FSM for the Y86-style core. Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/PC_UPDATE and drives the load strobes of the instruction counter, register file, ALU and data memory from the latched 4-bit icode. It sits between the instruction fetch path and the datapath and owns the per-instruction timing.

Parameters:
CNT_W, 16, width of the retired-instruction counter
ICODE_MAX, 4'hB, highest legal icode; anything above is illegal

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin execution; sampled only in IDLE
fetch_valid  in  1  instruction memory has icode_input ready
icode_input  in  4  icode of the fetched instruction
cond_true  in  1  condition-code result for jXX / cmovXX
mem_ready  in  1  data memory completes current access
fetch_req  out  1  request next instruction
ir_load  out  1  latch instruction register
alu_en  out  1  ALU operand/result capture
mem_rd  out  1  data memory read
mem_wr  out  1  data memory write
writeEnable0  out  1  register file write port E (dstE)
writeEnable1  out  1  register file write port M (dstM)
pc_write  out  1  update instruction counter
pc_sel  out  2  0 = valP, 1 = valC, 2 = valM
ins_len  out  4  byte length of latched instruction
state  out  3  current state encoding
halted  out  1  sticky, halt retired
error  out  1  sticky, illegal icode fetched
instr_count  out  CNT_W  retired instruction count

Behaviour:
- Reset (sync, high): state=IDLE; icode latch=0; every output 0; instr_count=0. Reset mid-instruction aborts; no partial strobes after the reset edge.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PC_UPDATE=6, STOP=7.
- IDLE: start=1 -> FETCH. start ignored in all other states.
- FETCH: fetch_req=1. ir_load=fetch_req&fetch_valid (same cycle). On the accept cycle, latch icode_input. If icode>ICODE_MAX -> STOP, error=1. Otherwise -> DECODE. No fetch_valid -> stay.
- DECODE (1 cycle): icode 0 -> STOP, halted=1. Icode 1 (nop) -> PC_UPDATE. Otherwise -> EXECUTE.
- EXECUTE (1 cycle): alu_en=1. Icodes 4,5,8,9,A,B -> MEMORY. Otherwise -> WRITEBACK.
- MEMORY: mem_rd=1 for 5,9,B; mem_wr=1 for 4,8,A. Strobe held until the cycle mem_ready=1, then -> WRITEBACK. Never both strobes asserted together.
- WRITEBACK (1 cycle):
  - writeEnable0=1 for 3,6,8,9,A,B, and for 2 only when cond_true=1.
  - writeEnable1=1 for 5,B.
  - Icodes 4 and 7 assert neither. Next state -> PC_UPDATE.
- PC_UPDATE (1 cycle): pc_write=1.
  - pc_sel=1 for 8, and for 7 when cond_true=1.
  - pc_sel=2 for 9.
  - All other cases pc_sel=0.
  - instr_count+=1, wraps at 2^CNT_W. Next state -> FETCH.
- STOP: terminal, all strobes 0, halted/error held until reset.
- ins_len is combinational from the latched icode: 0,1,9->1; 2,6,A,B->2; 7,8->9; 3,4,5->10; illegal->0.
- Strobe timing: all strobes except ir_load are Moore outputs, asserted only in their state and 0 in every other state.
- Latency, counted from the fetch-accept cycle to the next FETCH:
  - nop: 3 cycles.
  - OPq / rrmovq / irmovq / jXX: 5 cycles.
  - Memory ops with mem_ready already high: 6 cycles; each wait cycle adds 1.

Test Plan:
- Reset then start, fetch icode 1 (nop) -> states 1,2,6,1; pc_write pulses once with pc_sel=0; instr_count=1; no writeEnable.
- Fetch icode 3 (irmovq) -> ins_len=10; alu_en one cycle; writeEnable0=1 for one cycle, writeEnable1=0; pc_sel=0; 5 cycles to next FETCH.
- Fetch icode 5, mem_ready low for 3 cycles -> mem_rd high 4 cycles; writeEnable1=1 then pc_write; total 9 cycles.
- Fetch icode 7: cond_true=1 gives pc_sel=1; cond_true=0 gives pc_sel=0. Fetch icode 2 with cond_true=0 -> writeEnable0 stays 0.
- Fetch icode 0 -> STOP, halted=1. Fetch 4'hD on a fresh run -> STOP, error=1, instr_count unchanged. Both stay until reset.
- Assert reset while in MEMORY with mem_wr high -> next edge: state=0, mem_wr=0, instr_count=0; start then restarts cleanly.
